// File: rtl/bitbang_host_if.sv
// bitbang_host_if: bit-banged host port, deserialises 64 work bytes and serialises golden nonces
module bitbang_host_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_d,
  input  logic         rx_c,
  input  logic         rx_txr,
  input  logic         tx_c,
  output logic         tx_d,
  output logic [255:0] midstate,
  output logic [255:0] data,
  output logic         new_work,
  input  logic [31:0]  golden_nonce,
  input  logic         golden_nonce_valid,
  output logic         tx_busy,
  output logic         nonce_overflow,
  output logic         rx_frame_err
);
  localparam logic [1:0] IDLE = 2'd0, BITS = 2'd1, FLAG = 2'd2, DONE = 2'd3;
  logic [SYNC_STAGES-1:0] d_sync;
  logic [SYNC_STAGES:0]   c_sync, r_sync, t_sync;
  logic [7:0]   byte_sr, byte_nxt;
  logic [2:0]   bit_cnt, bit_idx;
  logic [6:0]   byte_cnt;
  logic [511:0] frame_sr;
  logic [1:0]   state, byte_idx;
  logic [31:0]  act, pend, a_n;
  logic         act_v, pend_v, a_v, p_v;
  logic         rx_txr_s, rx_rise, commit, tx_rise, good, retire, ld_a, ld_p, drop;
  assign rx_txr_s = r_sync[SYNC_STAGES-1];
  assign rx_rise  = c_sync[SYNC_STAGES-1] & ~c_sync[SYNC_STAGES];
  assign commit   = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
  assign tx_rise  = t_sync[SYNC_STAGES-1] & ~t_sync[SYNC_STAGES];
  assign byte_nxt = {d_sync[SYNC_STAGES-1], byte_sr[7:1]};
  assign good     = commit && byte_cnt == 7'd64 && bit_cnt == 3'd0;
  assign retire   = tx_rise && state == DONE;
  assign a_v      = retire ? pend_v : act_v;
  assign a_n      = retire ? pend : act;
  assign p_v      = retire ? 1'b0 : pend_v;
  assign ld_a     = golden_nonce_valid & ~a_v;
  assign ld_p     = golden_nonce_valid & a_v & ~p_v;
  assign drop     = golden_nonce_valid & a_v & p_v;
  assign tx_busy  = act_v | pend_v;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_sync <= '0;
      c_sync <= '0;
      r_sync <= '0;
      t_sync <= '0;
    end else begin
      d_sync <= {d_sync[SYNC_STAGES-2:0], rx_d};
      c_sync <= {c_sync[SYNC_STAGES-1:0], rx_c};
      r_sync <= {r_sync[SYNC_STAGES-1:0], rx_txr};
      t_sync <= {t_sync[SYNC_STAGES-1:0], tx_c};
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      byte_sr      <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      frame_sr     <= '0;
      midstate     <= '0;
      data         <= '0;
      new_work     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      new_work <= good;
      if (rx_txr_s) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        if (good) begin
          midstate <= frame_sr[511:256];
          data     <= frame_sr[255:0];
        end else if (commit && (byte_cnt != 7'd0 || bit_cnt != 3'd0))
          rx_frame_err <= 1'b1;
      end else if (rx_rise) begin
        byte_sr <= byte_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (byte_cnt == 7'd64)
            rx_frame_err <= 1'b1;
          else begin
            frame_sr <= {frame_sr[503:0], byte_nxt};
            byte_cnt <= byte_cnt + 7'd1;
          end
        end
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act            <= '0;
      pend           <= '0;
      act_v          <= 1'b0;
      pend_v         <= 1'b0;
      nonce_overflow <= 1'b0;
      state          <= IDLE;
      byte_idx       <= '0;
      bit_idx        <= '0;
      tx_d           <= 1'b0;
    end else begin
      act            <= ld_a ? golden_nonce : a_n;
      act_v          <= a_v | ld_a;
      pend           <= ld_p ? golden_nonce : pend;
      pend_v         <= p_v | ld_p;
      nonce_overflow <= nonce_overflow | drop;
      if (tx_rise)
        case (state)
          IDLE: begin
            tx_d     <= act_v;
            byte_idx <= '0;
            bit_idx  <= '0;
            state    <= act_v ? BITS : IDLE;
          end
          BITS: begin
            tx_d    <= act[{~byte_idx, bit_idx}];
            bit_idx <= bit_idx + 3'd1;
            state   <= bit_idx != 3'd7 ? BITS : byte_idx == 2'd3 ? DONE : FLAG;
          end
          FLAG: begin
            tx_d     <= 1'b1;
            byte_idx <= byte_idx + 2'd1;
            state    <= BITS;
          end
          default: begin
            tx_d  <= 1'b0;
            state <= IDLE;
          end
        endcase
    end
endmodule

// File: tb/tb_bitbang_host_if.sv
// tb_bitbang_host_if: randomized bench for bitbang_host_if against a byte/queue level model
module tb_bitbang_host_if;
  logic clk = 0, rst_n = 0, rx_d = 0, rx_c = 0, rx_txr = 0, tx_c = 0, golden_nonce_valid = 0;
  logic [31:0] golden_nonce = 0;
  logic tx_d, new_work, tx_busy, nonce_overflow, rx_frame_err;
  logic [255:0] midstate, data;
  int n_vec = 0, n_err = 0, nw_cnt = 0;
  logic [255:0] exp_ms = 0, exp_data = 0;
  logic exp_ovf = 0, exp_err = 0;
  logic [31:0] nq[$];
  bitbang_host_if dut (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_c(rx_c), .rx_txr(rx_txr), .tx_c(tx_c),
    .tx_d(tx_d), .midstate(midstate), .data(data), .new_work(new_work),
    .golden_nonce(golden_nonce), .golden_nonce_valid(golden_nonce_valid),
    .tx_busy(tx_busy), .nonce_overflow(nonce_overflow), .rx_frame_err(rx_frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (new_work) nw_cnt++;
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input int hp, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_d = b[i];
      clks(hp);
      rx_c = 1;
      clks(hp);
      rx_c = 0;
    end
  endtask
  task automatic strobe;
    rx_txr = 1;
    clks(8);
    rx_txr = 0;
    clks(8);
  endtask
  task automatic do_frame(input string tag, input int n, input int partial, input int hp,
                          input bit use_fixed, input logic [511:0] fixed);
    logic [7:0] fr[$];
    logic [7:0] b;
    int c0, commits;
    c0 = nw_cnt;
    commits = 0;
    for (int k = 0; k < n; k++) begin
      b = (use_fixed && k < 64) ? fixed[511-8*k -: 8] : 8'($urandom_range(0, 255));
      fr.push_back(b);
      send_byte(b, hp, 8);
    end
    if (partial > 0) send_byte(8'($urandom_range(0, 255)), hp, partial);
    strobe;
    if (n >= 64 && partial == 0) begin
      for (int k = 0; k < 64; k++)
        if (k < 32) exp_ms[255-8*k -: 8] = fr[k];
        else exp_data[255-8*(k-32) -: 8] = fr[k];
      commits = 1;
      if (n > 64) exp_err = 1;
    end else if (n > 0 || partial > 0) exp_err = 1;
    check({tag, " new_work"}, nw_cnt - c0, commits);
    check({tag, " midstate"}, midstate, exp_ms);
    check({tag, " data"}, data, exp_data);
    check({tag, " rx_frame_err"}, rx_frame_err, exp_err);
  endtask
  task automatic tx_pulse(output logic b);
    tx_c = 1;
    clks(5);
    tx_c = 0;
    clks(5);
    b = tx_d;
  endtask
  task automatic strobe_nonce(input logic [31:0] n);
    golden_nonce = n;
    golden_nonce_valid = 1;
    clks(1);
    golden_nonce_valid = 0;
    if (nq.size() < 2) nq.push_back(n);
    else exp_ovf = 1;
  endtask
  task automatic read_nonce(input string tag, input bit inj, input logic [31:0] nb, input logic [31:0] nc);
    logic [31:0] got, exp;
    logic b;
    int polls;
    got = 0;
    for (int j = 0; j < 4; j++) begin
      if (inj && j == 1) begin
        strobe_nonce(nb);
        strobe_nonce(nc);
      end
      polls = 0;
      do begin
        tx_pulse(b);
        polls++;
      end while (b !== 1'b1 && polls < 40);
      check({tag, " flag"}, b, 1);
      check({tag, " flag polls"}, polls, 1);
      for (int i = 0; i < 8; i++) begin
        tx_pulse(b);
        got[24-8*j+i] = b;
      end
    end
    check({tag, " busy before done"}, tx_busy, 1);
    tx_pulse(b);
    check({tag, " done tx_d"}, b, 0);
    exp = nq.pop_front();
    check({tag, " nonce"}, got, exp);
    check({tag, " busy after"}, tx_busy, nq.size() != 0);
    check({tag, " overflow"}, nonce_overflow, exp_ovf);
  endtask
  task automatic check_reset(input string tag);
    check({tag, " midstate"}, midstate, 0);
    check({tag, " data"}, data, 0);
    check({tag, " tx_d"}, tx_d, 0);
    check({tag, " new_work"}, new_work, 0);
    check({tag, " tx_busy"}, tx_busy, 0);
    check({tag, " nonce_overflow"}, nonce_overflow, 0);
    check({tag, " rx_frame_err"}, rx_frame_err, 0);
  endtask
  initial begin
    logic [255:0] ms0;
    logic b, any;
    int n, part;
    clks(3);
    check_reset("reset");
    rst_n = 1;
    clks(4);
    for (int i = 0; i < 8; i++) ms0[32*i +: 32] = $urandom;
    do_frame("load", 64, 0, 10, 1, {ms0, 256'h80000000_00000000_2194261a_9395e64d_bed17115});
    strobe_nonce(32'h0e33337a);
    read_nonce("nonce", 0, 0, 0);
    any = 0;
    for (int i = 0; i < 20; i++) begin
      tx_pulse(b);
      any |= b;
    end
    check("idle tx_d", any, 0);
    check("idle busy", tx_busy, 0);
    do_frame("short", 10, 0, 4, 0, 0);
    do_frame("reload", 64, 0, 4, 0, 0);
    strobe_nonce($urandom);
    read_nonce("nonce_a", 1, $urandom, $urandom);
    read_nonce("nonce_b", 0, 0, 0);
    strobe_nonce($urandom);
    for (int i = 0; i < 22; i++) tx_pulse(b);
    for (int k = 0; k < 29; k++) send_byte(8'($urandom_range(0, 255)), 4, 8);
    send_byte(8'($urandom_range(0, 255)), 4, 3);
    rst_n = 0;
    clks(3);
    nq.delete();
    exp_ms = 0;
    exp_data = 0;
    exp_err = 0;
    exp_ovf = 0;
    check_reset("midrst");
    rst_n = 1;
    clks(4);
    do_frame("fresh", 64, 0, 4, 0, 0);
    strobe_nonce($urandom);
    read_nonce("fresh nonce", 0, 0, 0);
    do_frame("long", 65, 0, 4, 0, 0);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 63)) : 64;
      part = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 7)) : 0;
      do_frame("rand", n, part, 4, 0, 0);
      strobe_nonce($urandom);
      if ($urandom_range(0, 1) == 1) strobe_nonce($urandom);
      while (nq.size() > 0) read_nonce("rand nonce", 0, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
